jtbubl_snd_comm: RTL
====================

// Module: jtbubl_snd_comm
// PURPOSE
// - Sound-CPU end of the main->sound command channel, plus a sound->main reply path.
// - Main CPU writes a command byte. The block holds it, flags it pending and raises NMI
//   on the sound Z80. The sound CPU reads the command, which acknowledges it.
// - The sound CPU writes a reply byte; the main CPU reads it back with a pending flag.
// - Sits between the main-CPU sound_cs decode region and the sound CPU's latch window.
// PARAMETERS
// - FIFO_AW  2  log2 of command FIFO depth; used only when JTBUBL_SND_FIFO_EN is defined.
// PORTS
// - clk24      in   1  system clock, 24 MHz
// - rst_n      in   1  asynchronous reset, active low
// - main_cs    in   1  main CPU access to the sound window (MREQ-qualified)
// - main_addr  in   2  main CPU address [1:0]
// - main_wrn   in   1  main CPU write strobe, active low
// - main_dout  in   8  main CPU write data
// - main_din   out  8  read data to main CPU
// - snd_cs     in   1  sound CPU access to the latch window
// - snd_addr   in   2  sound CPU address [1:0]
// - snd_wrn    in   1  sound CPU write strobe, active low
// - snd_dout   in   8  sound CPU write data
// - snd_din    out  8  read data to sound CPU
// - snd_nmi_n  out  1  NMI to sound CPU, active low
// BEHAVIOUR
// - Access strobes:
//   - wr_evt is the first clk24 cycle where cs && !wrn; a 1-cycle pulse from a registered
//     edge detect.
//   - rd_end is the first cycle after a cs && wrn access deasserts.
//   - Read side effects apply at rd_end, so data stays stable for the whole access.
// - Main map:
//   - 00 W: cmd <= main_dout, cmd_pend <= 1.
//   - 00 R: reply byte; rd_end clears rep_pend.
//   - 01 R: {5'b0, ovf, rep_pend, cmd_pend}; rd_end clears ovf.
//   - Other writes ignored; other reads return 8'hff.
// - Sound map:
//   - 00 R: cmd byte; rd_end clears cmd_pend.
//   - 00 W: reply <= snd_dout, rep_pend <= 1.
//   - 01 R: {6'b0, rep_pend, cmd_pend}.
//   - 01 W: nmi_en <= 1.
//   - 10 W: nmi_en <= 0.
//   - Others: read 8'hff / write ignored.
// - main_din and snd_din are combinational from the registers; zero added latency.
// - snd_nmi_n = ~(cmd_pend && nmi_en), registered: 1 cycle after cmd_pend rises.
//   - NMI is level, not pulse; it stays low until the command is read or nmi_en is cleared.
// - Overwrite:
//   - A main write to 00 while cmd_pend=1 replaces cmd and sets ovf (sticky).
//   - A sound reply overwrite is silent.
// - Simultaneous events:
//   - Set beats clear: a main cmd write in the same cycle as sound rd_end leaves
//     cmd_pend=1 with the new data.
//   - Same rule applies to rep_pend.
// - Reset values: cmd=0, reply=0, cmd_pend=0, rep_pend=0, ovf=0, nmi_en=0, snd_nmi_n=1,
//   edge-detect history=0.
// - Reset mid-access: all state clears at once. After release, an access already in
//   progress produces no wr_evt or rd_end.
// CONFIGURATION
// - JTBUBL_SND_FIFO_EN defined:
//   - Commands go through a 2**FIFO_AW deep FIFO; cmd_pend = !empty.
//   - Sound 00 R returns the head entry; rd_end pops it.
//   - A write when full is dropped and sets ovf.
//   - Write and pop in the same cycle are both honoured. When full, the pop makes room,
//     so the write is accepted.
//   - Reading while empty returns the last popped byte (0 after reset).
// - Undefined: single-byte latch with overwrite semantics as above; FIFO_AW unused.
// STRUCTURE
// - jtbubl_snd_comm_pkg holds:
//   - address constants: ADDR_DATA=2'd0, ADDR_STAT=2'd1, ADDR_NMIOFF=2'd2
//   - status bit indices: ST_CMD=0, ST_REP=1, ST_OVF=2
// - Sub-module jtbubl_snd_fifo (FIFO_AW parameter, push/pop/full/empty/head), instantiated
//   only under JTBUBL_SND_FIFO_EN.
// - Edge detect and register file stay in the top module.
// TESTING
// - Main writes 8'h5A to 00, nmi_en=1 -> snd_nmi_n low 1 cycle later; sound 00 R = 8'h5A;
//   snd_nmi_n high the cycle after rd_end.
// - nmi_en=0, main writes 8'h11 -> snd_nmi_n stays 1. Sound writes 01 -> snd_nmi_n low
//   next cycle. Sound writes 10 -> high next cycle.
// - Main writes 8'h01 then 8'h02 with no read -> sound reads 8'h02. Main 01 R = 8'h05;
//   a second 01 R = 8'h01.
// - Sound writes reply 8'hC3 -> main 01 R bit1=1, main 00 R=8'hC3, then bit1=0.
// - Main cmd write and sound rd_end in the same cycle -> cmd_pend=1, new byte readable.
// - FIFO_EN, FIFO_AW=2: push 8'hA0..8'hA4 -> 8'hA4 dropped, ovf=1;
//   pops return A0, A1, A2, A3, then empty.

Source files
------------

// File: rtl/jtbubl_snd_comm_pkg.sv
// Shared constants for the main<->sound CPU command channel.
package jtbubl_snd_comm_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STAT   = 2'd1;
  localparam logic [1:0] ADDR_NMIOFF = 2'd2;

  localparam int unsigned ST_CMD = 0;
  localparam int unsigned ST_REP = 1;
  localparam int unsigned ST_OVF = 2;

  localparam int unsigned NumSides = 2;
  localparam int unsigned SideMain = 0;
  localparam int unsigned SideSnd  = 1;

endpackage

// File: rtl/jtbubl_snd_fifo.sv
// Small command FIFO; a push while full is accepted only if a pop frees a slot that cycle.
module jtbubl_snd_fifo #(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               push_ok, pop_ok;

  assign full_o  = (cnt_q == (FIFO_AW + 1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (FIFO_AW)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (FIFO_AW)'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + (FIFO_AW + 1)'(1);
    else if (pop_ok && !push_ok) cnt_d = cnt_q - (FIFO_AW + 1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/jtbubl_snd_comm.sv
// Main->sound command latch (or FIFO with JTBUBL_SND_FIFO_EN) with sound->main reply byte.
// Define JTBUBL_SND_FIFO_EN to queue commands in a 2**FIFO_AW deep FIFO.
module jtbubl_snd_comm
  import jtbubl_snd_comm_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       clk24,
  input  logic       rst_n,
  input  logic       main_cs,
  input  logic [1:0] main_addr,
  input  logic       main_wrn,
  input  logic [7:0] main_dout,
  output logic [7:0] main_din,
  input  logic       snd_cs,
  input  logic [1:0] snd_addr,
  input  logic       snd_wrn,
  input  logic [7:0] snd_dout,
  output logic [7:0] snd_din,
  output logic       snd_nmi_n
);

  logic [NumSides-1:0]      cs_v, wrn_v, wr_act, rd_act, wr_evt, rd_end;
  logic [NumSides-1:0]      armed_q, armed_d, wr_q, rd_q;
  logic [NumSides-1:0][1:0] addr_v, rd_addr_q, rd_addr_d;

  assign cs_v   = {snd_cs, main_cs};
  assign wrn_v  = {snd_wrn, main_wrn};
  assign addr_v = {snd_addr, main_addr};

  // armed_q stays low until cs drops, so an access spanning reset release is ignored.
  always_comb begin
    wr_act    = '0;
    rd_act    = '0;
    wr_evt    = '0;
    rd_end    = '0;
    armed_d   = armed_q;
    rd_addr_d = rd_addr_q;
    for (int i = 0; i < NumSides; i++) begin
      wr_act[i]  = cs_v[i] && !wrn_v[i] && armed_q[i];
      rd_act[i]  = cs_v[i] && wrn_v[i] && armed_q[i];
      wr_evt[i]  = wr_act[i] && !wr_q[i];
      rd_end[i]  = rd_q[i] && !rd_act[i];
      armed_d[i] = armed_q[i] || !cs_v[i];
      if (rd_act[i]) rd_addr_d[i] = addr_v[i];
    end
  end

  logic main_cmd_wr, main_rep_rd, main_ovf_clr, snd_cmd_rd, snd_rep_wr, nmi_on, nmi_off;

  assign main_cmd_wr  = wr_evt[SideMain] && (main_addr == ADDR_DATA);
  assign main_rep_rd  = rd_end[SideMain] && (rd_addr_q[SideMain] == ADDR_DATA);
  assign main_ovf_clr = rd_end[SideMain] && (rd_addr_q[SideMain] == ADDR_STAT);
  assign snd_cmd_rd   = rd_end[SideSnd] && (rd_addr_q[SideSnd] == ADDR_DATA);
  assign snd_rep_wr   = wr_evt[SideSnd] && (snd_addr == ADDR_DATA);
  assign nmi_on       = wr_evt[SideSnd] && (snd_addr == ADDR_STAT);
  assign nmi_off      = wr_evt[SideSnd] && (snd_addr == ADDR_NMIOFF);

  logic       cmd_pend, ovf_set;
  logic [7:0] cmd_rd_data;

`ifdef JTBUBL_SND_FIFO_EN
  logic       fifo_full, fifo_empty, fifo_pop;
  logic [7:0] fifo_head, last_q, last_d;

  assign fifo_pop    = snd_cmd_rd && !fifo_empty;
  assign cmd_pend    = !fifo_empty;
  assign ovf_set     = main_cmd_wr && fifo_full && !fifo_pop;
  assign cmd_rd_data = fifo_empty ? last_q : fifo_head;
  assign last_d      = fifo_pop ? fifo_head : last_q;

  jtbubl_snd_fifo #(
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .clk_i  (clk24),
    .rst_ni (rst_n),
    .push_i (main_cmd_wr),
    .pop_i  (fifo_pop),
    .data_i (main_dout),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) last_q <= '0;
    else        last_q <= last_d;
  end
`else
  logic [7:0] cmd_q, cmd_d;
  logic       cmd_pend_q, cmd_pend_d;
  logic       unused_fifo_aw;

  assign unused_fifo_aw = ^FIFO_AW;
  assign cmd_pend       = cmd_pend_q;
  assign cmd_rd_data    = cmd_q;
  // An overwrite racing the sound read is not an overflow: the old byte was consumed.
  assign ovf_set        = main_cmd_wr && cmd_pend_q && !snd_cmd_rd;

  always_comb begin
    cmd_d      = main_cmd_wr ? main_dout : cmd_q;
    cmd_pend_d = cmd_pend_q;
    if (snd_cmd_rd)  cmd_pend_d = 1'b0;
    if (main_cmd_wr) cmd_pend_d = 1'b1;
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= '0;
      cmd_pend_q <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      cmd_pend_q <= cmd_pend_d;
    end
  end
`endif

  logic [7:0] reply_q, reply_d;
  logic       rep_pend_q, rep_pend_d, ovf_q, ovf_d, nmi_en_q, nmi_en_d, nmi_n_q, nmi_n_d;

  always_comb begin
    reply_d    = snd_rep_wr ? snd_dout : reply_q;
    rep_pend_d = rep_pend_q;
    ovf_d      = ovf_q;
    nmi_en_d   = nmi_en_q;
    if (main_rep_rd)  rep_pend_d = 1'b0;
    if (snd_rep_wr)   rep_pend_d = 1'b1;
    if (main_ovf_clr) ovf_d = 1'b0;
    if (ovf_set)      ovf_d = 1'b1;
    if (nmi_on)       nmi_en_d = 1'b1;
    if (nmi_off)      nmi_en_d = 1'b0;
    nmi_n_d = ~(cmd_pend && nmi_en_q);
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      armed_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      rd_addr_q  <= '0;
      reply_q    <= '0;
      rep_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      nmi_en_q   <= 1'b0;
      nmi_n_q    <= 1'b1;
    end else begin
      armed_q    <= armed_d;
      wr_q       <= wr_act;
      rd_q       <= rd_act;
      rd_addr_q  <= rd_addr_d;
      reply_q    <= reply_d;
      rep_pend_q <= rep_pend_d;
      ovf_q      <= ovf_d;
      nmi_en_q   <= nmi_en_d;
      nmi_n_q    <= nmi_n_d;
    end
  end

  assign snd_nmi_n = nmi_n_q;

  logic [7:0] main_st, snd_st;

  always_comb begin
    main_st         = '0;
    main_st[ST_CMD] = cmd_pend;
    main_st[ST_REP] = rep_pend_q;
    main_st[ST_OVF] = ovf_q;
    snd_st          = '0;
    snd_st[ST_CMD]  = cmd_pend;
    snd_st[ST_REP]  = rep_pend_q;
    case (main_addr)
      ADDR_DATA: main_din = reply_q;
      ADDR_STAT: main_din = main_st;
      default:   main_din = 8'hff;
    endcase
    case (snd_addr)
      ADDR_DATA: snd_din = cmd_rd_data;
      ADDR_STAT: snd_din = snd_st;
      default:   snd_din = 8'hff;
    endcase
  end

endmodule
